// File: rtl/npu_chunk_pkg.sv
// Shared sizing defaults and bank state encoding for the ping-pong sparse chunk store.
package npu_chunk_pkg;
   localparam int MEM_SIZE_DEF        = 256;
   localparam int BUS_SIZE_DEF        = 32;
   localparam int PREFIX_SUM_SIZE_DEF = 32;
   localparam int DATA_W_DEF          = 8;
   localparam int BEATS_DEF           = MEM_SIZE_DEF / BUS_SIZE_DEF;
   localparam int SMAP_RD_NUM_DEF     = MEM_SIZE_DEF / PREFIX_SUM_SIZE_DEF;

   typedef enum logic [1:0] {
      EMPTY   = 2'd0,
      FILLING = 2'd1,
      FULL    = 2'd2
   } bank_state_e;
endpackage

// File: rtl/data_chunk_pingpong_if.sv
// Loader beat stream and PE read port of the ping-pong chunk store.
interface data_chunk_pingpong_if
   import npu_chunk_pkg::*;
#(
   parameter int MEM_SIZE        = MEM_SIZE_DEF,
   parameter int BUS_SIZE        = BUS_SIZE_DEF,
   parameter int PREFIX_SUM_SIZE = PREFIX_SUM_SIZE_DEF,
   parameter int DATA_W          = DATA_W_DEF
) ();
   localparam int BEATS       = MEM_SIZE / BUS_SIZE;
   localparam int SMAP_RD_NUM = MEM_SIZE / PREFIX_SUM_SIZE;
   localparam int AW          = $clog2(MEM_SIZE) + 1;
   localparam int SW          = $clog2(SMAP_RD_NUM);
   localparam int BW          = $clog2(BEATS) + 1;

   logic                       wr_valid_i;
   logic                       wr_ready_o;
   logic [BUS_SIZE-1:0]        wr_sparsemap_i;
   logic [BUS_SIZE*DATA_W-1:0] wr_nonzero_data_i;
   logic                       wr_last_i;
   logic                       rd_valid_o;
   logic                       rd_release_i;
   logic [AW-1:0]              rd_addr_i;
   logic [DATA_W-1:0]          rd_data_o;
   logic [SW-1:0]              rd_sparsemap_addr_i;
   logic [PREFIX_SUM_SIZE-1:0] rd_sparsemap_o;
   logic [BW-1:0]              rd_beats_o;
   logic [AW-1:0]              rd_nz_count_o;

   modport slave (
      input  wr_valid_i, wr_sparsemap_i, wr_nonzero_data_i, wr_last_i,
      input  rd_release_i, rd_addr_i, rd_sparsemap_addr_i,
      output wr_ready_o, rd_valid_o, rd_data_o, rd_sparsemap_o, rd_beats_o, rd_nz_count_o
   );

   modport master (
      output wr_valid_i, wr_sparsemap_i, wr_nonzero_data_i, wr_last_i,
      output rd_release_i, rd_addr_i, rd_sparsemap_addr_i,
      input  wr_ready_o, rd_valid_o, rd_data_o, rd_sparsemap_o, rd_beats_o, rd_nz_count_o
   );
endinterface

// File: rtl/data_chunk_bank.sv
// One chunk bank: sparsemap and nonzero byte storage, beat/popcount counters, masked reads.
module data_chunk_bank
   import npu_chunk_pkg::*;
#(
   parameter int MEM_SIZE        = MEM_SIZE_DEF,
   parameter int BUS_SIZE        = BUS_SIZE_DEF,
   parameter int PREFIX_SUM_SIZE = PREFIX_SUM_SIZE_DEF,
   parameter int DATA_W          = DATA_W_DEF
) (
   input  logic                                          clk,
   input  logic                                          rst_n,
   input  logic                                          wr_en,
   input  logic                                          wr_first,
   input  logic [BUS_SIZE-1:0]                           wr_sparsemap,
   input  logic [BUS_SIZE*DATA_W-1:0]                    wr_data,
   input  logic [$clog2(MEM_SIZE):0]                     rd_addr,
   input  logic [$clog2(MEM_SIZE/PREFIX_SUM_SIZE)-1:0]   rd_sparsemap_addr,
   output logic [DATA_W-1:0]                             rd_data,
   output logic [PREFIX_SUM_SIZE-1:0]                    rd_sparsemap,
   output logic [$clog2(MEM_SIZE/BUS_SIZE):0]            beats,
   output logic [$clog2(MEM_SIZE):0]                     nz_count
);
   localparam int AW = $clog2(MEM_SIZE) + 1;
   localparam int MW = $clog2(MEM_SIZE);
   localparam int BW = $clog2(MEM_SIZE / BUS_SIZE) + 1;

   logic [MEM_SIZE-1:0] smap;
   logic [DATA_W-1:0]   mem [MEM_SIZE];
   logic [BW-1:0]       beat_cnt;
   logic [AW-1:0]       nz_cnt;
   logic [BW-1:0]       idx;
   logic [AW-1:0]       beat_pop;
   logic [MW-1:0]       wr_base;
   logic [MW-1:0]       rd_idx;
   logic [MW-1:0]       rd_sbase;
   int                  limit;
   int                  smap_pos;

   // A new chunk overwrites from beat 0; stale bytes past the close are hidden by the read mask.
   assign idx      = wr_first ? '0 : beat_cnt;
   assign beat_pop = AW'($countones(wr_sparsemap));
   assign wr_base  = MW'(int'(idx) * BUS_SIZE);

   always_ff @(posedge clk) begin
      if (wr_en) begin
         smap[wr_base +: BUS_SIZE] <= wr_sparsemap;
         for (int i = 0; i < BUS_SIZE; i++)
            mem[wr_base + MW'(i)] <= wr_data[i*DATA_W +: DATA_W];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         beat_cnt <= '0;
         nz_cnt   <= '0;
      end else if (wr_en) begin
         beat_cnt <= idx + BW'(1);
         nz_cnt   <= (wr_first ? '0 : nz_cnt) + beat_pop;
      end
   end

   // Data addresses are 1-based; address 0 and anything past the written beats read as zero.
   assign limit    = int'(beat_cnt) * BUS_SIZE;
   assign rd_idx   = MW'(rd_addr - AW'(1));
   assign smap_pos = int'(rd_sparsemap_addr) * PREFIX_SUM_SIZE;
   assign rd_sbase = MW'(smap_pos);

   assign rd_data      = (rd_addr == '0 || int'(rd_addr) > limit) ? '0 : mem[rd_idx];
   assign rd_sparsemap = (smap_pos >= limit) ? '0 : smap[rd_sbase +: PREFIX_SUM_SIZE];
   assign beats        = beat_cnt;
   assign nz_count     = nz_cnt;
endmodule

// File: rtl/data_chunk_pingpong.sv
// Double-buffered sparse chunk store: loader fills one bank while the PE reads the other.
module data_chunk_pingpong
   import npu_chunk_pkg::*;
#(
   parameter int MEM_SIZE        = MEM_SIZE_DEF,
   parameter int BUS_SIZE        = BUS_SIZE_DEF,
   parameter int PREFIX_SUM_SIZE = PREFIX_SUM_SIZE_DEF,
   parameter int DATA_W          = DATA_W_DEF
) (
   input logic                  clk_i,
   input logic                  rst_ni,
   data_chunk_pingpong_if.slave bus
);
   localparam int BEATS = MEM_SIZE / BUS_SIZE;
   localparam int AW    = $clog2(MEM_SIZE) + 1;
   localparam int BW    = $clog2(BEATS) + 1;

   localparam logic [1:0] ST_EMPTY   = EMPTY;
   localparam logic [1:0] ST_FILLING = FILLING;
   localparam logic [1:0] ST_FULL    = FULL;

   logic [1:0][1:0]            state;
   logic                       wr_bank;
   logic                       rd_bank;
   logic                       accept;
   logic                       first;
   logic                       close;
   logic                       release_ok;
   logic [BW-1:0]              beat_idx;
   logic [BW-1:0]              bank_beats [2];
   logic [AW-1:0]              bank_nz    [2];
   logic [DATA_W-1:0]          bank_data  [2];
   logic [PREFIX_SUM_SIZE-1:0] bank_smap  [2];

   assign bus.wr_ready_o = (state[wr_bank] != ST_FULL);
   assign accept         = bus.wr_valid_i && bus.wr_ready_o;
   assign first          = (state[wr_bank] == ST_EMPTY);
   assign beat_idx       = first ? '0 : bank_beats[wr_bank];
   assign close          = accept && (bus.wr_last_i || beat_idx == BW'(BEATS - 1));
   assign release_ok     = bus.rd_release_i && (state[rd_bank] == ST_FULL);

   for (genvar g = 0; g < 2; g++) begin : g_bank
      data_chunk_bank #(
         .MEM_SIZE        (MEM_SIZE),
         .BUS_SIZE        (BUS_SIZE),
         .PREFIX_SUM_SIZE (PREFIX_SUM_SIZE),
         .DATA_W          (DATA_W)
      ) u_bank (
         .clk               (clk_i),
         .rst_n             (rst_ni),
         .wr_en             (accept && (wr_bank == 1'(g))),
         .wr_first          (first),
         .wr_sparsemap      (bus.wr_sparsemap_i),
         .wr_data           (bus.wr_nonzero_data_i),
         .rd_addr           (bus.rd_addr_i),
         .rd_sparsemap_addr (bus.rd_sparsemap_addr_i),
         .rd_data           (bank_data[g]),
         .rd_sparsemap      (bank_smap[g]),
         .beats             (bank_beats[g]),
         .nz_count          (bank_nz[g])
      );
   end

   // Release only ever hits a FULL bank and a beat only a non-FULL one, so per-bank updates never collide.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state   <= {ST_EMPTY, ST_EMPTY};
         wr_bank <= 1'b0;
         rd_bank <= 1'b0;
      end else begin
         for (int b = 0; b < 2; b++) begin
            if (release_ok && rd_bank == 1'(b))
               state[b] <= ST_EMPTY;
            else if (accept && wr_bank == 1'(b))
               state[b] <= close ? ST_FULL : ST_FILLING;
         end
         wr_bank <= wr_bank ^ close;
         rd_bank <= rd_bank ^ release_ok;
      end
   end

   assign bus.rd_valid_o     = (state[rd_bank] == ST_FULL);
   assign bus.rd_data_o      = bus.rd_valid_o ? bank_data[rd_bank]  : '0;
   assign bus.rd_sparsemap_o = bus.rd_valid_o ? bank_smap[rd_bank]  : '0;
   assign bus.rd_beats_o     = bus.rd_valid_o ? bank_beats[rd_bank] : '0;
   assign bus.rd_nz_count_o  = bus.rd_valid_o ? bank_nz[rd_bank]    : '0;
endmodule

// File: tb/tb_data_chunk_pingpong.sv
// Directed bench for data_chunk_pingpong: table-driven read checks plus handshake corner sequences.
module tb_data_chunk_pingpong;
   import npu_chunk_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   data_chunk_pingpong_if bus_if ();
   data_chunk_pingpong dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus_if));

   typedef struct {
      int          grp;
      logic [8:0]  addr;
      logic [2:0]  sidx;
      logic [7:0]  exp_data;
      logic [31:0] exp_smap;
   } rvec_t;

   rvec_t vecs[$];
   int tests = 0;
   int fails = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic add(input int g, input int a, input int s, input int d, input logic [31:0] sm);
      rvec_t v;
      v.grp = g; v.addr = 9'(a); v.sidx = 3'(s); v.exp_data = 8'(d); v.exp_smap = sm;
      vecs.push_back(v);
   endtask

   function automatic logic [BUS_SIZE_DEF*8-1:0] gen(input logic [7:0] seed);
      logic [BUS_SIZE_DEF*8-1:0] d;
      for (int k = 0; k < BUS_SIZE_DEF; k++) d[k*8 +: 8] = seed + 8'(k);
      return d;
   endfunction

   task automatic run_group(input int g);
      foreach (vecs[i]) begin
         if (vecs[i].grp == g) begin
            bus_if.rd_addr_i = vecs[i].addr;
            bus_if.rd_sparsemap_addr_i = vecs[i].sidx;
            #1;
            chk($sformatf("g%0d_data_addr%0d", g, vecs[i].addr), 32'(bus_if.rd_data_o), 32'(vecs[i].exp_data));
            chk($sformatf("g%0d_smap_idx%0d", g, vecs[i].sidx), bus_if.rd_sparsemap_o, vecs[i].exp_smap);
         end
      end
   endtask

   task automatic send_beat(input logic [31:0] sm, input logic [7:0] seed, input logic last);
      int waited = 0;
      bus_if.wr_valid_i = 1'b1;
      bus_if.wr_sparsemap_i = sm;
      bus_if.wr_nonzero_data_i = gen(seed);
      bus_if.wr_last_i = last;
      while (!bus_if.wr_ready_o && waited < 50) begin
         @(posedge clk); #1;
         waited++;
      end
      if (!bus_if.wr_ready_o) begin
         tests++; fails++;
         $display("FAIL beat_timeout: wr_ready_o stayed 0 for %0d cycles, expected 1", waited);
      end else begin
         @(posedge clk); #1;
      end
      bus_if.wr_valid_i = 1'b0;
      bus_if.wr_last_i = 1'b0;
   endtask

   task automatic release_bank();
      bus_if.rd_release_i = 1'b1;
      @(posedge clk); #1;
      bus_if.rd_release_i = 1'b0;
   endtask

   task automatic chk_status(input string tag, input int valid, input int beats, input int nz);
      chk({tag, "_valid"}, 32'(bus_if.rd_valid_o), 32'(valid));
      chk({tag, "_beats"}, 32'(bus_if.rd_beats_o), 32'(beats));
      chk({tag, "_nz"},    32'(bus_if.rd_nz_count_o), 32'(nz));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      // full 8-beat chunk, bytes k=k within each beat
      add(0, 1, 0, 8'h00, 32'h0000_00FF);
      add(0, 33, 1, 8'h00, 32'h0000_00FF);
      add(0, 0, SMAP_RD_NUM_DEF-1, 8'h00, 32'h0000_00FF);
      add(0, 2, 0, 8'h01, 32'h0000_00FF);
      add(0, 32, 0, 8'h1F, 32'h0000_00FF);
      add(0, 256, 7, 8'h1F, 32'h0000_00FF);
      // 3-beat early close in bank 1
      add(1, 1, 0, 8'h10, 32'h0000_000F);
      add(1, 33, 1, 8'h20, 32'hFFFF_0000);
      add(1, 96, 2, 8'h4F, 32'h8000_0001);
      add(1, 97, 3, 8'h00, 32'h0000_0000);
      // 2-beat chunk over stale full-chunk contents of bank 0
      add(2, 1, 0, 8'h40, 32'h0000_0003);
      add(2, 64, 1, 8'h6F, 32'h0000_0007);
      add(2, 65, 2, 8'h00, 32'h0000_0000);
      add(2, 66, 2, 8'h00, 32'h0000_0000);
      // bank 1 filled during overlap
      add(3, 1, 0, 8'h80, 32'h0101_0101);
      add(3, 33, 1, 8'h81, 32'h0101_0101);
      add(3, 256, 7, 8'hA6, 32'h0101_0101);
      add(3, 257, 7, 8'h00, 32'h0101_0101);
      // bank 0 full of ones
      add(4, 1, 0, 8'hC0, 32'hFFFF_FFFF);
      add(4, 256, 7, 8'hE6, 32'hFFFF_FFFF);
      // held single-beat chunk
      add(5, 1, 0, 8'h77, 32'hFFFF_FFFF);
      add(5, 32, 0, 8'h96, 32'hFFFF_FFFF);
      add(5, 33, 1, 8'h00, 32'h0000_0000);
      // chunk closed together with a release
      add(6, 1, 0, 8'h11, 32'h0000_FFFF);
      add(6, 33, 1, 8'h22, 32'h0000_0001);
      add(6, 64, 1, 8'h41, 32'h0000_0001);
      add(6, 65, 2, 8'h00, 32'h0000_0000);
      // first chunk after reset
      add(7, 1, 0, 8'h99, 32'h0000_0001);
      add(7, 2, 0, 8'h9A, 32'h0000_0001);
      add(7, 33, 1, 8'h00, 32'h0000_0000);

      bus_if.wr_valid_i = 1'b0;
      bus_if.wr_sparsemap_i = '0;
      bus_if.wr_nonzero_data_i = '0;
      bus_if.wr_last_i = 1'b0;
      bus_if.rd_release_i = 1'b0;
      bus_if.rd_addr_i = 9'd1;
      bus_if.rd_sparsemap_addr_i = '0;
      #2;
      chk("rst_ready", 32'(bus_if.wr_ready_o), 1);
      chk_status("rst", 0, 0, 0);
      chk("rst_data", 32'(bus_if.rd_data_o), 0);
      chk("rst_smap", bus_if.rd_sparsemap_o, 0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      // full chunk
      for (int b = 0; b < BEATS_DEF; b++) begin
         if (b == BEATS_DEF - 1) chk("full_valid_before_last", 32'(bus_if.rd_valid_o), 0);
         send_beat(32'h0000_00FF, 8'h00, 1'b0);
      end
      chk_status("full", 1, 8, 64);
      run_group(0);
      release_bank();
      chk("full_released_valid", 32'(bus_if.rd_valid_o), 0);

      // early close
      send_beat(32'h0000_000F, 8'h10, 1'b0);
      send_beat(32'hFFFF_0000, 8'h20, 1'b0);
      send_beat(32'h8000_0001, 8'h30, 1'b1);
      chk_status("early", 1, 3, 22);
      run_group(1);
      release_bank();

      // ping-pong overlap
      send_beat(32'h0000_0003, 8'h40, 1'b0);
      send_beat(32'h0000_0007, 8'h50, 1'b1);
      chk_status("stale", 1, 2, 5);
      run_group(2);
      for (int b = 0; b < BEATS_DEF; b++) begin
         chk($sformatf("pp_ready_beat%0d", b), 32'(bus_if.wr_ready_o), 1);
         send_beat(32'h0101_0101, 8'(8'h80 + b), 1'b0);
      end
      chk_status("pp_old_bank", 1, 2, 5);
      release_bank();
      chk_status("pp_new_bank", 1, 8, 32);
      run_group(3);

      // backpressure with both banks full
      for (int b = 0; b < BEATS_DEF; b++) send_beat(32'hFFFF_FFFF, 8'(8'hC0 + b), 1'b0);
      bus_if.wr_valid_i = 1'b1;
      bus_if.wr_sparsemap_i = 32'hFFFF_FFFF;
      bus_if.wr_nonzero_data_i = gen(8'h77);
      bus_if.wr_last_i = 1'b1;
      for (int c = 0; c < 3; c++) begin
         chk($sformatf("bp_ready_low%0d", c), 32'(bus_if.wr_ready_o), 0);
         @(posedge clk); #1;
      end
      chk_status("bp_hold", 1, 8, 32);
      bus_if.rd_release_i = 1'b1;
      @(posedge clk); #1;
      bus_if.rd_release_i = 1'b0;
      chk("bp_ready_after_rel", 32'(bus_if.wr_ready_o), 1);
      chk_status("bp_bank0", 1, 8, 256);
      @(posedge clk); #1;
      bus_if.wr_valid_i = 1'b0;
      bus_if.wr_last_i = 1'b0;
      chk("bp_ready_both_full", 32'(bus_if.wr_ready_o), 0);
      run_group(4);
      release_bank();
      chk_status("bp_held", 1, 1, 32);
      run_group(5);

      // closing beat and release in the same cycle
      send_beat(32'h0000_FFFF, 8'h11, 1'b0);
      chk("cr_valid_during_fill", 32'(bus_if.rd_valid_o), 1);
      bus_if.wr_valid_i = 1'b1;
      bus_if.wr_sparsemap_i = 32'h0000_0001;
      bus_if.wr_nonzero_data_i = gen(8'h22);
      bus_if.wr_last_i = 1'b1;
      bus_if.rd_release_i = 1'b1;
      @(posedge clk); #1;
      bus_if.wr_valid_i = 1'b0;
      bus_if.wr_last_i = 1'b0;
      bus_if.rd_release_i = 1'b0;
      chk("cr_ready", 32'(bus_if.wr_ready_o), 1);
      chk_status("cr", 1, 2, 17);
      run_group(6);

      // async reset in the middle of a fill
      for (int b = 0; b < 4; b++) send_beat(32'h0000_0001, 8'h55, 1'b0);
      bus_if.rd_addr_i = 9'd1;
      bus_if.rd_sparsemap_addr_i = '0;
      chk("mid_valid_before_rst", 32'(bus_if.rd_valid_o), 1);
      #2 rst_n = 1'b0;
      #1;
      chk_status("arst", 0, 0, 0);
      chk("arst_data", 32'(bus_if.rd_data_o), 0);
      chk("arst_smap", bus_if.rd_sparsemap_o, 0);
      chk("arst_ready", 32'(bus_if.wr_ready_o), 1);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      send_beat(32'h0000_0001, 8'h99, 1'b1);
      chk_status("post_rst", 1, 1, 1);
      run_group(7);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
